and_unit_arbiter: RTL and testbench
===================================

Name: and_unit_arbiter

Overview:
- Round-robin scheduler that shares one 2-input gate cell (the team's andgate, propagation delay #2) among N requesters.
- Grants one requester at a time and drives that requester's registered operands onto the shared gate.
- Waits SETTLE clock cycles for the gate output to settle, then returns the captured result with a one-cycle ack.
- Sits between the requester testbenches/datapath and the single shared gate instance.

Parameters:
- N, 4, number of requesters (N >= 2).
- IDX_W, 2, index width; must be at least clog2(N).
- SETTLE, 2, cycles to wait after driving operands before sampling unit_s (SETTLE >= 1; must exceed gate delay / clock period).
- CNT_W, 2, counter width; must hold SETTLE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  per-requester request; hold high with stable operands until ack.
- a  input  N  operand A, one bit per requester.
- b  input  N  operand B, one bit per requester.
- gnt  output  N  one-hot grant, registered.
- ack  output  N  one-hot, one-cycle completion pulse, registered.
- s_out  output  1  result for the acked requester; valid while ack != 0, holds otherwise.
- busy  output  1  high whenever state != IDLE.
- unit_a  output  1  operand A to the shared gate, registered.
- unit_b  output  1  operand B to the shared gate, registered.
- unit_s  input  1  output of the shared gate.

Behaviour:
- Async reset (rst=1, any time) forces all outputs to 0: gnt, ack, s_out, unit_a, unit_b, busy. Also forces state=IDLE, ptr=0, cnt=0. An in-flight transaction is aborted and gets no ack.
- States: IDLE, WAIT, ACK; 2-bit encoding.
- IDLE, req != 0 at edge: winner = first set bit scanning ptr, ptr+1, ... mod N.
  - gnt <= onehot(winner); unit_a <= a[winner]; unit_b <= b[winner].
  - cnt <= SETTLE; state <= WAIT.
- IDLE, req == 0: stay; outputs hold.
- WAIT: if cnt == 1, then s_out <= unit_s, ack <= onehot(winner), state <= ACK; else cnt <= cnt - 1.
- ACK (one cycle): ack <= 0; gnt <= 0; unit_a, unit_b <= 0; ptr <= (winner+1) mod N; state <= IDLE.
- Timing with req sampled at edge E0:
  - gnt high from E0 to E0+SETTLE+1.
  - ack high for exactly one cycle, E0+SETTLE to E0+SETTLE+1.
  - Next grant at E0+SETTLE+2 at the earliest.
  - Throughput: one operation per SETTLE+2 cycles.
- Operands are captured at grant. Changes to a/b or a req drop during WAIT do not affect the result; the ack still pulses.
- req still high in the ACK cycle is ignored. If it is still high in the following IDLE, it re-competes under the updated ptr, so a different pending requester wins first (fairness).
- Simultaneous requests: exactly one winner, and gnt/ack are never multi-hot.
- ptr wrap: winner N-1 gives ptr = 0.
- s_out holds its last value outside ack cycles.

Decomposition:
- Shared include file and_arb_defs.vh:
  - state localparams S_IDLE=0, S_WAIT=1, S_ACK=2;
  - default N, SETTLE.
- One sub-module, rr_pick (combinational):
  - inputs req[N], ptr[IDX_W];
  - outputs winner[IDX_W], any.
- The arbiter holds the FSM, counter and operand registers. The bench instantiates andgate as the shared unit (unit_a, unit_b -> unit_s).

Test Plan:
- Reset: rst=1 mid-WAIT with gnt=0010 -> all outputs 0 immediately (before next clk); no ack afterwards; after release first grant goes to lowest set req from index 0.
- Single: req=0010, a=0010, b=0010, SETTLE=2 -> gnt=0010 after E0; unit_a=unit_b=1; ack=0010 with s_out=1 after E2 for one cycle; gnt=0 after E3.
- AND truth: requester 0 with (a,b)=(1,0), then (1,1) -> s_out=0, then s_out=1; each ack one cycle.
- Round-robin: req=1111 held with a=b=1111 -> grant order 0,1,2,3,0; grants spaced 4 cycles apart; gnt always one-hot.
- Operand/req change: req0 granted, then a[0] toggles 1->0 and req drops during WAIT -> s_out reflects captured operands; ack=0001 still issued.
- Idle hold: req=0000 for 10 cycles after a transaction -> busy=0, gnt=ack=0, s_out keeps last value.

Source files
------------

// File: rtl/and_unit_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter that time-shares one AND gate.
// Encoded states: IDLE=0, WAIT=1, ACK=2.
package and_unit_arbiter_pkg;

  localparam int N_DEF      = 4;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  function automatic logic [31:0] onehot32(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/and_unit_arbiter_if.sv
// Requester-side and shared-gate-side signals of the arbiter.
// The slave modport is the arbiter. The master modport is the requesters together with the gate.
interface and_unit_arbiter_if
  import and_unit_arbiter_pkg::*;
#(
  parameter int N = N_DEF
);
  logic [N-1:0] req;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic         s_out;
  logic         busy;
  logic         unit_a;
  logic         unit_b;
  logic         unit_s;

  modport slave (
    input  req, a, b, unit_s,
    output gnt, ack, s_out, busy, unit_a, unit_b
  );

  modport master (
    output req, a, b, unit_s,
    input  gnt, ack, s_out, busy, unit_a, unit_b
  );
endinterface

// File: rtl/and_unit_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request scanning upward from ptr.
// The scan wraps past N-1 back to index 0.
module and_unit_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  int idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        winner = IDX_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter for one shared 2-input AND gate. It grants one requester and drives
// that requester's operands to the gate. After SETTLE cycles it captures the result and sends a one-cycle ack.
module and_unit_arbiter
  import and_unit_arbiter_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int IDX_W  = 2,
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNT_W  = 2
) (
  input logic               clk,
  input logic               rst,
  and_unit_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [N-1:0]     ack_q, ack_d;
  logic             s_out_q, s_out_d;
  logic             unit_a_q, unit_a_d;
  logic             unit_b_q, unit_b_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  and_unit_arbiter_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    s_out_d  = s_out_q;
    unit_a_d = unit_a_q;
    unit_b_d = unit_b_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          winner_d = pick_idx;
          gnt_d    = N'(onehot32(32'(pick_idx)));
          unit_a_d = bus.a[pick_idx];
          unit_b_d = bus.b[pick_idx];
          cnt_d    = CNT_W'(SETTLE);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Operands were latched at grant, so a/b or req movement here is irrelevant.
        if (cnt_q == CNT_W'(1)) begin
          s_out_d = bus.unit_s;
          ack_d   = N'(onehot32(32'(winner_q)));
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        ack_d    = '0;
        gnt_d    = '0;
        unit_a_d = 1'b0;
        unit_b_d = 1'b0;
        ptr_d    = (winner_q == IDX_W'(N - 1)) ? '0 : winner_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      s_out_q  <= 1'b0;
      unit_a_q <= 1'b0;
      unit_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      s_out_q  <= s_out_d;
      unit_a_q <= unit_a_d;
      unit_b_q <= unit_b_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.s_out  = s_out_q;
  assign bus.unit_a = unit_a_q;
  assign bus.unit_b = unit_b_q;
  assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter with N=4 and SETTLE=2. The shared gate is modelled
// as an AND with a #2 delay.
module tb_and_unit_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  and_unit_arbiter_if #(.N(4)) bus ();

  and_unit_arbiter #(
    .N      (4),
    .IDX_W  (2),
    .SETTLE (2),
    .CNT_W  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign #2 bus.unit_s = bus.unit_a & bus.unit_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    32'(bus.gnt),    32'h0);
    check({tag, "_ack"},    32'(bus.ack),    32'h0);
    check({tag, "_s_out"},  32'(bus.s_out),  32'h0);
    check({tag, "_unit_a"}, 32'(bus.unit_a), 32'h0);
    check({tag, "_unit_b"}, 32'(bus.unit_b), 32'h0);
    check({tag, "_busy"},   32'(bus.busy),   32'h0);
  endtask

  // Runs one full transaction with SETTLE=2: grant at E0, ack at E2, and idle again after E3.
  task automatic run_txn(input string tag, input logic [3:0] r, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] exp_gnt, input logic exp_s);
    bus.req = r;
    bus.a   = ra;
    bus.b   = rb;
    tick();
    check({tag, "_gnt"},    32'(bus.gnt),    32'(exp_gnt));
    check({tag, "_unit_a"}, 32'(bus.unit_a), 32'(|(ra & exp_gnt)));
    check({tag, "_unit_b"}, 32'(bus.unit_b), 32'(|(rb & exp_gnt)));
    check({tag, "_busy"},   32'(bus.busy),   32'h1);
    check({tag, "_ack_e0"}, 32'(bus.ack),    32'h0);
    tick();
    check({tag, "_ack_e1"}, 32'(bus.ack),    32'h0);
    tick();
    check({tag, "_ack_e2"}, 32'(bus.ack),    32'(exp_gnt));
    check({tag, "_s_out"},  32'(bus.s_out),  32'(exp_s));
    check({tag, "_gnt_e2"}, 32'(bus.gnt),    32'(exp_gnt));
    bus.req = 4'b0000;
    tick();
    check({tag, "_ack_e3"}, 32'(bus.ack),    32'h0);
    check({tag, "_gnt_e3"}, 32'(bus.gnt),    32'h0);
    check({tag, "_ua_e3"},  32'(bus.unit_a), 32'h0);
    check({tag, "_busy_e3"}, 32'(bus.busy),  32'h0);
    check({tag, "_s_hold"}, 32'(bus.s_out),  32'(exp_s));
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    bus.req = 4'b0000;
    bus.a   = 4'b0000;
    bus.b   = 4'b0000;
    tick();
    tick();
    check_all_zero("reset_state");
    rst = 1'b0;
    tick();

    // ptr starts at 0. The only request is from 1, so ptr becomes 2.
    run_txn("single", 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b1);

    // Each requester-0 transaction leaves ptr at 1.
    run_txn("and_10", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    run_txn("and_11", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1);
    run_txn("and_01", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0);

    // Operands are latched at grant: a[0] drops and req drops during WAIT.
    bus.req = 4'b0001;
    bus.a   = 4'b0001;
    bus.b   = 4'b0001;
    tick();
    check("opchg_gnt", 32'(bus.gnt), 32'h1);
    bus.a   = 4'b0000;
    bus.req = 4'b0000;
    tick();
    check("opchg_ack_e1", 32'(bus.ack), 32'h0);
    tick();
    check("opchg_ack", 32'(bus.ack), 32'h1);
    check("opchg_s_out", 32'(bus.s_out), 32'h1);
    tick();
    check("opchg_ack_off", 32'(bus.ack), 32'h0);
    check("opchg_idle", 32'(bus.busy), 32'h0);

    // Apply an asynchronous reset in the middle of WAIT while requester 1 holds the grant.
    bus.req = 4'b0010;
    bus.a   = 4'b0010;
    bus.b   = 4'b0010;
    tick();
    check("rst_pre_gnt", 32'(bus.gnt), 32'h2);
    tick();
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    bus.req = 4'b1001;
    bus.a   = 4'b1001;
    bus.b   = 4'b1001;
    tick();
    check("rst_no_ack0", 32'(bus.ack), 32'h0);
    tick();
    check("rst_no_ack1", 32'(bus.ack), 32'h0);
    rst = 1'b0;
    // ptr was reset to 0, so requester 0 wins over 3. The old ptr of 1 would have picked 3.
    run_txn("post_rst", 4'b1001, 4'b1001, 4'b1001, 4'b0001, 1'b1);

    // Requester 3 wins with ptr at 1, and the pointer then wraps to 0.
    run_txn("wrap", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0);

    // With all four held, grants rotate 0,1,2,3,0 and are spaced 4 cycles apart.
    bus.req = 4'b1111;
    bus.a   = 4'b1111;
    bus.b   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_g;
      exp_g = 4'(4'b0001 << (i % 4));
      tick();
      check($sformatf("rr%0d_gnt", i), 32'(bus.gnt), 32'(exp_g));
      tick();
      check($sformatf("rr%0d_gnt_w", i), 32'(bus.gnt), 32'(exp_g));
      tick();
      check($sformatf("rr%0d_ack", i), 32'(bus.ack), 32'(exp_g));
      check($sformatf("rr%0d_s", i), 32'(bus.s_out), 32'h1);
      if (i == 4) bus.req = 4'b0000;
      tick();
      check($sformatf("rr%0d_gap", i), 32'(bus.gnt), 32'h0);
    end

    // With no requests, the arbiter stays idle and s_out keeps the last result.
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle%0d_busy", i), 32'(bus.busy), 32'h0);
      check($sformatf("idle%0d_gnt_ack", i), 32'({bus.gnt, bus.ack}), 32'h0);
      check($sformatf("idle%0d_s", i), 32'(bus.s_out), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
